edge_detect_multi: RTL and testbench
====================================

Name: edge_detect_multi

Overview:
Parameterised multi-channel successor to the single-bit edge detector. Each of CH asynchronous inputs passes through a configurable synchroniser and a glitch filter, then produces registered rise, fall and mode-selected event pulses. Events also set per-channel sticky flags and feed a shared saturating event counter. The block sits between raw external or status lines and the interrupt/status logic.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (0..3; 0 = input used directly)
FILT_LEN, 3, consecutive cycles a new level must persist before it is accepted (>=1; 1 = no filtering)
CNT_W, 8, width of the shared event counter
RST_LVL, 0, level loaded into the synchroniser and filtered-state flops on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
a  in  CH  raw input lines
en  in  CH  per-channel output enable
mode  in  2*CH  per-channel event select, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
sticky_clr  in  CH  per-channel sticky clear, one cycle
cnt_clr  in  1  clear for evt_cnt
rise  out  CH  one-cycle rising-edge pulse
down  out  CH  one-cycle falling-edge pulse
evt  out  CH  one-cycle mode-qualified event pulse
sticky  out  CH  latched event flags
evt_cnt  out  CNT_W  saturating total event count

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst=1: sync flops and filtered level f = RST_LVL; filter counters = 0; rise, down, evt, sticky and evt_cnt = 0, immediately, with no clock required.
- Synchroniser: a chain of SYNC_STAGES flops per channel; s = last stage output (s = a when SYNC_STAGES=0).
- Filter, per channel, evaluated at each edge:
  - s==f: counter cleared.
  - s!=f and counter==FILT_LEN-1: f<=s and counter cleared.
  - s!=f otherwise: counter increments.
- Latency: if edge k is the first edge sampling a new stable level, f updates at edge k+SYNC_STAGES+FILT_LEN-1. The corresponding pulse is registered at that same edge and is high for exactly one cycle.
- Glitches: a level held for fewer than FILT_LEN cycles at s produces no pulse. A reversion clears the counter.
- Pulse outputs:
  - rise[i] = 1 when f[i] goes 0->1; down[i] = 1 when f[i] goes 1->0.
  - Both are gated by en[i] and are not affected by mode.
  - evt[i] = (rise & mode[2i]) | (down & mode[2i+1]), also gated by en[i].
- en=0: synchroniser and filter keep tracking, so re-enabling never creates a false edge. Pulses, sticky set and counting are suppressed.
- Sticky: set by an evt pulse, cleared by sticky_clr. If set and clear occur in the same cycle, set wins.
- Counter:
  - At the edge where evt is registered, evt_cnt <= min(base + popcount(evt_next), 2^CNT_W-1).
  - base = 0 if cnt_clr, else evt_cnt.
  - Saturates at the maximum and never wraps.
- Reset mid-filter: a partial count is discarded, f returns to RST_LVL, and no pulse is emitted on release unless the input differs from RST_LVL and then passes the filter.
- rise and down never both assert on one channel in the same cycle. Multiple channels may pulse simultaneously.

Test Plan:
(All scenarios: CH=4, SYNC_STAGES=2, FILT_LEN=3, CNT_W=4, RST_LVL=0, 20 ns clock, mode=all 11, en=4'hF unless stated.)
1. Reset release: a=4'hF held through reset, rst deasserted before edge k -> rise=4'hF for one cycle at edge k+4; down=0; sticky=4'hF; evt_cnt=4.
2. Glitch: a[0] low for 2 cycles, then high -> no down or rise. a[0] low for 3 cycles -> down[0] 4 edges after the first low sample, then rise[0] 3 cycles after that.
3. Mode: mode[3:2]=10, toggle a[1] 1->0->1 with 5-cycle holds -> down[1], rise[1] each pulse once; evt[1] only with down[1]; evt_cnt +1.
4. Saturation and clear: 20 qualified events -> evt_cnt=15 and holds. cnt_clr in the same cycle as 2 events -> evt_cnt=2.
5. Sticky race: sticky_clr[2]=1 in the same cycle evt[2] registers -> sticky[2]=1; sticky_clr[2] alone next cycle -> 0.
6. Gating and reset:
   - en[3]=0 during a[3] rising edge, en[3]=1 later -> no rise[3] and no sticky at any time.
   - rst pulsed 1 cycle while a[0] is mid-filter (counter=1) -> all outputs 0 immediately, no pulse until a full 3-cycle filter completes.

Source files
------------

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser and glitch filter, registered
// rise/fall/event pulses, sticky event flags and a shared saturating event counter.
module edge_detect_multi #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned CNT_W       = 8,
  parameter bit          RST_LVL     = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH-1:0]      a,
  input  logic [CH-1:0]      en,
  input  logic [2*CH-1:0]    mode,
  input  logic [CH-1:0]      sticky_clr,
  input  logic               cnt_clr,
  output logic [CH-1:0]      rise,
  output logic [CH-1:0]      down,
  output logic [CH-1:0]      evt,
  output logic [CH-1:0]      sticky,
  output logic [CNT_W-1:0]   evt_cnt
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned PW = $clog2(CH + 1);
  localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CH-1:0] s;

  // Synchroniser chain; with zero stages the raw input feeds the filter directly.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = a;
    end else begin : g_sync
      logic [CH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= {CH{RST_LVL}};
        end else begin
          sync_q[0] <= a;
          for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  function automatic logic [PW-1:0] popcount(input logic [CH-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(CH); i++) n = n + PW'(v[i]);
    return n;
  endfunction

  logic [CH-1:0]    f_q, f_next;
  logic [CW-1:0]    cnt_q [CH];
  logic [CW-1:0]    cnt_next [CH];
  logic [CH-1:0]    rise_next, down_next, evt_next, sticky_next;
  logic [CNT_W-1:0] evt_cnt_next;
  logic [CNT_W-1:0] cnt_base;
  logic [SW-1:0]    cnt_sum;

  // Filter: a differing level must be seen FILT_LEN times in a row to be accepted.
  always_comb begin
    f_next = f_q;
    for (int i = 0; i < int'(CH); i++) begin
      cnt_next[i] = '0;
      if (s[i] != f_q[i]) begin
        if (cnt_q[i] == CW'(FILT_LEN - 1)) f_next[i] = s[i];
        else                               cnt_next[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Pulse, sticky and counter next-state; enables gate outputs only, never tracking.
  always_comb begin
    rise_next = ~f_q & f_next & en;
    down_next = f_q & ~f_next & en;
    evt_next  = '0;
    for (int i = 0; i < int'(CH); i++) begin
      evt_next[i] = (rise_next[i] & mode[2*i]) | (down_next[i] & mode[2*i+1]);
    end
    sticky_next  = (sticky & ~sticky_clr) | evt_next;
    cnt_base     = cnt_clr ? '0 : evt_cnt;
    cnt_sum      = SW'(cnt_base) + SW'(popcount(evt_next));
    evt_cnt_next = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q     <= {CH{RST_LVL}};
      for (int i = 0; i < int'(CH); i++) cnt_q[i] <= '0;
      rise    <= '0;
      down    <= '0;
      evt     <= '0;
      sticky  <= '0;
      evt_cnt <= '0;
    end else begin
      f_q     <= f_next;
      for (int i = 0; i < int'(CH); i++) cnt_q[i] <= cnt_next[i];
      rise    <= rise_next;
      down    <= down_next;
      evt     <= evt_next;
      sticky  <= sticky_next;
      evt_cnt <= evt_cnt_next;
    end
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi (CH=4, SYNC_STAGES=2, FILT_LEN=3, CNT_W=4).
module tb_edge_detect_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, en, sticky_clr;
  logic [7:0] mode;
  logic       cnt_clr;
  logic [3:0] rise, down, evt, sticky;
  logic [3:0] evt_cnt;

  int total = 0;
  int bad   = 0;

  edge_detect_multi #(
    .CH(4), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(4), .RST_LVL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .en(en), .mode(mode),
    .sticky_clr(sticky_clr), .cnt_clr(cnt_clr),
    .rise(rise), .down(down), .evt(evt), .sticky(sticky), .evt_cnt(evt_cnt)
  );

  always #10 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset release with all inputs high
    rst = 1'b1; a = 4'hF; en = 4'hF; mode = 8'hFF; sticky_clr = 4'h0; cnt_clr = 1'b0;
    #5;
    chk("reset_outputs", {16'h0, rise, down, evt, sticky}, 32'h0);
    chk("reset_cnt", 32'(evt_cnt), 32'h0);
    cyc(3);
    rst = 1'b0;
    cyc(4);
    chk("rel_rise_early", 32'(rise), 32'h0);
    cyc(1);
    chk("rel_rise", 32'(rise), 32'hF);
    chk("rel_down", 32'(down), 32'h0);
    chk("rel_evt", 32'(evt), 32'hF);
    chk("rel_sticky", 32'(sticky), 32'hF);
    chk("rel_cnt", 32'(evt_cnt), 32'd4);
    cyc(1);
    chk("rel_rise_one_cycle", 32'(rise), 32'h0);
    chk("rel_cnt_hold", 32'(evt_cnt), 32'd4);

    // 2: 2-cycle glitch is filtered, 3-cycle low passes
    a = 4'hE;
    cyc(2);
    a = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("glitch_quiet", {24'h0, rise, down}, 32'h0);
    end
    a = 4'hE;
    cyc(3);
    a = 4'hF;
    cyc(1);
    chk("low3_down_early", 32'(down), 32'h0);
    cyc(1);
    chk("low3_down", 32'(down), 32'h1);
    chk("low3_evt", 32'(evt), 32'h1);
    chk("low3_cnt", 32'(evt_cnt), 32'd5);
    cyc(2);
    chk("low3_rise_early", {24'h0, rise, down}, 32'h0);
    cyc(1);
    chk("low3_rise", 32'(rise), 32'h1);
    chk("low3_cnt2", 32'(evt_cnt), 32'd6);

    // 3: channel 1 in fall-only mode
    mode = 8'hFB;
    cyc(2);
    a = 4'hD;
    cyc(4);
    chk("mode_down_early", 32'(down), 32'h0);
    cyc(1);
    chk("mode_down", 32'(down), 32'h2);
    chk("mode_down_evt", 32'(evt), 32'h2);
    chk("mode_down_rise", 32'(rise), 32'h0);
    chk("mode_cnt1", 32'(evt_cnt), 32'd7);
    a = 4'hF;
    cyc(5);
    chk("mode_rise", 32'(rise), 32'h2);
    chk("mode_rise_evt", 32'(evt), 32'h0);
    chk("mode_cnt2", 32'(evt_cnt), 32'd7);
    mode = 8'hFF;
    cyc(2);

    // 4: saturation, then clear together with two events
    a = 4'h0;
    cyc(6);
    chk("sat_cnt11", 32'(evt_cnt), 32'd11);
    for (int t = 0; t < 4; t++) begin
      a = (t % 2 == 0) ? 4'hF : 4'h0;
      cyc(6);
    end
    chk("sat_cnt15", 32'(evt_cnt), 32'd15);
    chk("sat_sticky", 32'(sticky), 32'hF);
    cyc(3);
    chk("sat_hold", 32'(evt_cnt), 32'd15);
    a = 4'h3;
    cyc(4);
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    chk("clr_rise", 32'(rise), 32'h3);
    chk("clr_cnt", 32'(evt_cnt), 32'd2);
    cyc(1);
    chk("clr_cnt_hold", 32'(evt_cnt), 32'd2);

    // 5: sticky set beats same-cycle clear
    sticky_clr = 4'hF;
    cyc(1);
    sticky_clr = 4'h0;
    chk("sticky_clear_all", 32'(sticky), 32'h0);
    a = 4'h7;
    cyc(4);
    sticky_clr = 4'h4;
    cyc(1);
    chk("race_evt", 32'(evt), 32'h4);
    chk("race_sticky", 32'(sticky), 32'h4);
    cyc(1);
    sticky_clr = 4'h0;
    chk("race_clear", 32'(sticky), 32'h0);
    chk("race_cnt", 32'(evt_cnt), 32'd3);

    // 6a: disabled channel tracks silently, no false edge on re-enable
    en = 4'h7;
    a = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("gate_off", {29'h0, rise[3], evt[3], sticky[3]}, 32'h0);
    end
    en = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("gate_on", {29'h0, rise[3], evt[3], sticky[3]}, 32'h0);
    end
    chk("gate_cnt", 32'(evt_cnt), 32'd3);

    // 6b: reset while channel 0 is mid-filter
    a = 4'hE;
    cyc(3);
    rst = 1'b1;
    #2;
    chk("midrst_async", {12'h0, rise, down, evt, sticky, evt_cnt}, 32'h0);
    cyc(1);
    chk("midrst_held", {12'h0, rise, down, evt, sticky, evt_cnt}, 32'h0);
    rst = 1'b0;
    cyc(4);
    chk("midrst_rise_early", {24'h0, rise, down}, 32'h0);
    cyc(1);
    chk("midrst_rise", 32'(rise), 32'hE);
    chk("midrst_down", 32'(down), 32'h0);
    chk("midrst_cnt", 32'(evt_cnt), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
